debug_mem_arbiter: RTL

Shares the processor's single data-memory port between the core load/store unit and the debug unit. It also executes debug register-file accesses. The block receives debug transactions from the debug-mode controller as a level request (`tx_flag`, `mode`, `address_bridged`, `data_bridged`) and answers with a one-cycle `doneSending` pulse plus `data_internal`. It sits between the debug-mode controller, the core pipeline, the data memory and the register-file debug port.

---
 rtl/debug_mem_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/debug_mem_arbiter.sv
// Shares the single data-memory port between the core load/store unit and
// the debug unit, and executes debug register-file accesses.
//
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   tx_flag, mode,
//   address_bridged,
//   data_bridged                 debug transaction request (level, held until doneSending)
//   doneSending, data_internal,
//   dbg_error                    debug completion pulse, read result and error flag
//   core_req, core_we,
//   core_addr, core_wdata        core memory request
//   core_rdata, core_gnt,
//   core_stall                   core read data, completion pulse, stall
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ack                      data-memory port
//   rf_we, rf_addr, rf_wdata,
//   rf_rdata                     register-file debug port
module debug_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_flag,
  input  logic [2:0]  mode,
  input  logic [31:0] address_bridged,
  input  logic [31:0] data_bridged,
  output logic        doneSending,
  output logic [31:0] data_internal,
  output logic        dbg_error,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_gnt,
  output logic        core_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata
);

  localparam int unsigned CntW = 10;

  typedef enum logic [2:0] {
    StIdle,
    StCore,
    StDbgMem,
    StDbgRf,
    StDone,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        mem_req_d, mem_we_d, core_gnt_d, done_d, err_d, rf_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d, core_rdata_d, data_d, rf_wdata_d;
  logic [4:0]  rf_addr_d;

  logic dbg_is_mem, dbg_is_rf, dbg_aligned;

  assign dbg_is_mem  = (mode == 3'b001) || (mode == 3'b010);
  assign dbg_is_rf   = (mode == 3'b101) || (mode == 3'b110);
  assign dbg_aligned = (address_bridged[1:0] == 2'b00);

  assign core_stall = core_req & ~core_gnt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    core_rdata_d = core_rdata;
    core_gnt_d   = 1'b0;
    done_d       = 1'b0;
    data_d       = data_internal;
    err_d        = dbg_error;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr;
    rf_wdata_d   = rf_wdata;

    unique case (state_q)
      StIdle: begin
        // Core has fixed priority; a pending debug request waits for the next idle cycle.
        if (core_req) begin
          state_d     = StCore;
          mem_req_d   = 1'b1;
          mem_we_d    = core_we;
          mem_addr_d  = core_addr;
          mem_wdata_d = core_wdata;
        end else if (tx_flag) begin
          if (dbg_is_mem && dbg_aligned) begin
            state_d     = StDbgMem;
            mem_req_d   = 1'b1;
            mem_we_d    = (mode == 3'b010);
            mem_addr_d  = address_bridged;
            mem_wdata_d = data_bridged;
            cnt_d       = '0;
          end else if (dbg_is_rf) begin
            state_d    = StDbgRf;
            rf_addr_d  = address_bridged[4:0];
            rf_wdata_d = data_bridged;
            // x0 is hard-wired: the write completes without a strobe.
            rf_we_d    = (mode == 3'b110) && (address_bridged[4:0] != 5'd0);
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            data_d  = ERR_WORD;
            err_d   = 1'b1;
          end
        end
      end

      StCore: begin
        if (mem_ack) begin
          state_d      = StIdle;
          core_rdata_d = mem_rdata;
          core_gnt_d   = 1'b1;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
        end
      end

      StDbgMem: begin
        // An ack in the same cycle as the timeout compare wins.
        if (mem_ack) begin
          state_d   = StDone;
          done_d    = 1'b1;
          data_d    = mem_we ? data_bridged : mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          state_d   = StDone;
          done_d    = 1'b1;
          data_d    = ERR_WORD;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDbgRf: begin
        state_d = StDone;
        done_d  = 1'b1;
        err_d   = 1'b0;
        data_d  = (mode == 3'b101) ? rf_rdata : data_bridged;
      end

      StDone: begin
        state_d = StRelease;
      end

      StRelease: begin
        // Hold off everything until the controller drops its request.
        if (!tx_flag) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      core_rdata    <= '0;
      core_gnt      <= 1'b0;
      doneSending   <= 1'b0;
      data_internal <= '0;
      dbg_error     <= 1'b0;
      rf_we         <= 1'b0;
      rf_addr       <= '0;
      rf_wdata      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req       <= mem_req_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      core_rdata    <= core_rdata_d;
      core_gnt      <= core_gnt_d;
      doneSending   <= done_d;
      data_internal <= data_d;
      dbg_error     <= err_d;
      rf_we         <= rf_we_d;
      rf_addr       <= rf_addr_d;
      rf_wdata      <= rf_wdata_d;
    end
  end

endmodule
